// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, requests words from instruction memory,
// buffers one instruction for decode and resolves branch/jump targets.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   imem_req/addr/ack   word request to instruction memory (held until ack)
//   imem_rdata          returned instruction word
//   instr, opcode       buffered instruction and its [31:26] field
//   instr_pc, link_addr address of buffered instruction and that plus 4
//   instr_valid/ready   handshake with decode; consume when both high
//   branch/alu_zero/jump  decode controls for the instruction being consumed
//   halted              fetch stopped by the halt opcode (6'b111111)
//   retired_count       instructions consumed since reset (wraps)
module instruction_fetch #(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              branch,
    input  logic              alu_zero,
    input  logic              jump,
    output logic [ADDR_W-1:0] link_addr,
    output logic              halted,
    output logic [31:0]       retired_count
);

    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_FULL,
        S_HALT
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              halted_q, halted_d;
    logic [31:0]       retired_q, retired_d;

    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] jmp_tgt;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] br_tgt;

    // Targets are formed from the buffered instruction, so they are
    // stable for the whole time decode may take to accept it.
    always_comb begin
        seq_pc        = instr_pc_q + ADDR_W'(4);
        // Jump keeps the region bits above 28 of the sequential PC.
        jmp_tgt       = seq_pc;
        jmp_tgt[27:0] = {instr_q[25:0], 2'b00};
        br_off        = {{(ADDR_W-18){instr_q[15]}}, instr_q[15:0], 2'b00};
        br_tgt        = seq_pc + br_off;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        halted_d   = halted_q;
        retired_d  = retired_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    pc_d       = pc_q + ADDR_W'(4);
                    state_d    = S_FULL;
                end
            end
            S_FULL: begin
                if (instr_ready) begin
                    retired_d = retired_q + 32'd1;
                    if (instr_q[31:26] == OP_HALT) begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        state_d = S_FETCH;
                        // pc already holds instr_pc+4 for the fall-through case.
                        if (jump) begin
                            pc_d = jmp_tgt;
                        end else if (branch && alu_zero) begin
                            pc_d = br_tgt;
                        end
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            instr_pc_q <= '0;
            halted_q   <= 1'b0;
            retired_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            halted_q   <= halted_d;
            retired_q  <= retired_d;
        end
    end

    assign imem_req      = (state_q == S_FETCH);
    assign imem_addr     = pc_q;
    assign instr_valid   = (state_q == S_FULL);
    assign instr         = instr_q;
    assign opcode        = instr_q[31:26];
    assign instr_pc      = instr_pc_q;
    assign link_addr     = seq_pc;
    assign halted        = halted_q;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed scenarios plus a randomized
// run checked against a transaction-level fetch model.
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch;
    logic        alu_zero;
    logic        jump;
    logic [31:0] link_addr;
    logic        halted;
    logic [31:0] retired_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [logic [31:0]];
    bit          rand_mem = 0;

    instruction_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .opcode(opcode), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .branch(branch), .alu_zero(alu_zero), .jump(jump),
        .link_addr(link_addr), .halted(halted),
        .retired_count(retired_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Memory contents: explicit entries, else a non-halt pattern
    // (directed) or a lazily drawn random word (random run).
    task automatic get_word(input logic [31:0] a, output logic [31:0] w);
        if (!mem.exists(a)) begin
            if (rand_mem) mem[a] = $urandom;
            else mem[a] = {6'b001000, a[27:2]};
        end
        w = mem[a];
    endtask

    task automatic tick();
        logic [31:0] w;
        @(posedge clk);
        #1;
        get_word(imem_addr, w);
        imem_rdata = w;
    endtask

    task automatic do_reset();
        reset = 1; imem_ack = 0; instr_ready = 0;
        branch = 0; alu_zero = 0; jump = 0;
        tick(); tick();
        reset = 0;
    endtask

    task automatic test_reset();
        rand_mem = 0; mem.delete();
        imem_rdata = 32'hDEAD_BEEF;
        do_reset();
        checks++;
        if ({imem_req, instr_valid, halted} !== 3'b000)
            $display("FAIL rst_flags: got %b want 000", {imem_req, instr_valid, halted});
        else ;
        if ({imem_req, instr_valid, halted} !== 3'b000) errors++;
        checks++;
        if (instr !== 32'd0 || instr_pc !== 32'd0) begin
            errors++;
            $display("FAIL rst_instr: got %h/%h want 0/0", instr, instr_pc);
        end
        checks++;
        if (retired_count !== 32'd0 || imem_addr !== 32'd0) begin
            errors++;
            $display("FAIL rst_cnt_addr: got %0d/%h want 0/0", retired_count, imem_addr);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            errors++;
            $display("FAIL rst_first_req: got req=%b addr=%h want 1/0", imem_req, imem_addr);
        end
    endtask

    task automatic test_seq_fetch();
        logic [31:0] w;
        rand_mem = 0; mem.delete();
        do_reset();
        imem_ack = 1; instr_ready = 1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (k % 2 == 1) begin
                if ({imem_req, instr_valid} !== 2'b10 || imem_addr !== 32'((k - 1) * 2)) begin
                    errors++;
                    $display("FAIL seq_req k=%0d: got req=%b v=%b addr=%h want 1/0/%h",
                             k, imem_req, instr_valid, imem_addr, 32'((k - 1) * 2));
                end
            end else begin
                get_word(32'((k - 2) * 2), w);
                if ({imem_req, instr_valid} !== 2'b01 || instr !== w ||
                    opcode !== w[31:26] || instr_pc !== 32'((k - 2) * 2)) begin
                    errors++;
                    $display("FAIL seq_buf k=%0d: got v=%b instr=%h pc=%h want 1/%h/%h",
                             k, instr_valid, instr, instr_pc, w, 32'((k - 2) * 2));
                end
            end
        end
        tick();
        checks++;
        if (retired_count !== 32'd4 || imem_addr !== 32'h10) begin
            errors++;
            $display("FAIL seq_retired: got %0d addr=%h want 4/10", retired_count, imem_addr);
        end
    endtask

    task automatic test_delayed_ack();
        logic [31:0] exp_addr;
        int waited;
        int nfetch;
        rand_mem = 0; mem.delete();
        do_reset();
        instr_ready = 1;
        exp_addr = 0; waited = 0; nfetch = 0;
        for (int c = 0; c < 40 && nfetch < 4; c++) begin
            tick();
            checks++;
            if (imem_req && instr_valid) begin
                errors++;
                $display("FAIL dly_excl: req and valid both high");
            end
            if (imem_req) begin
                checks++;
                if (imem_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL dly_addr: got %h want %h", imem_addr, exp_addr);
                end
                if (imem_addr == 32'h8 && waited < 3) begin
                    waited++;
                    imem_ack = 0;
                end else begin
                    imem_ack = 1;
                    exp_addr += 4;
                    nfetch++;
                end
            end else begin
                imem_ack = 0;
                if (instr_valid) begin
                    checks++;
                    if (instr_pc !== exp_addr - 32'd4) begin
                        errors++;
                        $display("FAIL dly_ipc: got %h want %h", instr_pc, exp_addr - 32'd4);
                    end
                end
            end
        end
        checks++;
        if (nfetch != 4 || waited != 3) begin
            errors++;
            $display("FAIL dly_progress: got fetches=%0d waits=%0d want 4/3", nfetch, waited);
        end
        tick();
        imem_ack = 0;
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'hC) begin
            errors++;
            $display("FAIL dly_last: got v=%b pc=%h want 1/c", instr_valid, instr_pc);
        end
    endtask

    task automatic test_branch();
        logic [31:0] want [2];
        want[0] = 32'h24;
        want[1] = 32'h1C;
        for (int az = 1; az >= 0; az--) begin
            rand_mem = 0; mem.delete();
            mem[32'h0]  = {6'b000010, 26'h8};
            mem[32'h20] = {6'b000100, 5'd1, 5'd2, 16'hFFFE};
            do_reset();
            imem_ack = 1; instr_ready = 1;
            tick();
            tick();
            jump = 1;
            tick();
            jump = 0;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin
                errors++;
                $display("FAIL br_jmp_to20: got req=%b addr=%h want 1/20", imem_req, imem_addr);
            end
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'h20 || opcode !== 6'b000100) begin
                errors++;
                $display("FAIL br_buf: got v=%b pc=%h op=%b want 1/20/000100",
                         instr_valid, instr_pc, opcode);
            end
            branch = 1; alu_zero = az[0];
            tick();
            branch = 0; alu_zero = 0;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== want[az]) begin
                errors++;
                $display("FAIL br_target az=%0d: got %h want %h", az, imem_addr, want[az]);
            end
        end
    endtask

    task automatic test_jump();
        rand_mem = 0; mem.delete();
        mem[32'h0]    = {6'b000010, 26'h400};
        mem[32'h1000] = {6'b000011, 26'h0000040};
        do_reset();
        imem_ack = 1; instr_ready = 1;
        tick();
        tick();
        jump = 1;
        tick();
        jump = 0;
        checks++;
        if (imem_addr !== 32'h1000) begin
            errors++;
            $display("FAIL jal_reach: got %h want 1000", imem_addr);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || link_addr !== 32'h1004 || opcode !== 6'b000011) begin
            errors++;
            $display("FAIL jal_link: got v=%b link=%h op=%b want 1/1004/000011",
                     instr_valid, link_addr, opcode);
        end
        jump = 1; branch = 1; alu_zero = 1;
        tick();
        jump = 0; branch = 0; alu_zero = 0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL jal_prio: got req=%b addr=%h want 1/100", imem_req, imem_addr);
        end
    endtask

    task automatic test_stall_halt();
        logic [31:0] w0;
        rand_mem = 0; mem.delete();
        mem[32'h4] = 32'hFC00_0000;
        get_word(32'h0, w0);
        do_reset();
        imem_ack = 1; instr_ready = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            branch = 1'($urandom); jump = 1'($urandom); alu_zero = 1'($urandom);
            tick();
            checks++;
            if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== w0 ||
                instr_pc !== 32'h0 || imem_addr !== 32'h4 || retired_count !== 32'd0) begin
                errors++;
                $display("FAIL stall_hold i=%0d: got v=%b req=%b instr=%h pc=%h addr=%h cnt=%0d",
                         i, instr_valid, imem_req, instr, instr_pc, imem_addr, retired_count);
            end
        end
        branch = 0; jump = 0; alu_zero = 0;
        instr_ready = 1;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4 || retired_count !== 32'd1) begin
            errors++;
            $display("FAIL stall_resume: got req=%b addr=%h cnt=%0d want 1/4/1",
                     imem_req, imem_addr, retired_count);
        end
        tick();
        checks++;
        if (opcode !== 6'b111111 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL halt_buf: got op=%b v=%b want 111111/1", opcode, instr_valid);
        end
        jump = 1; branch = 1; alu_zero = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
                retired_count !== 32'd2) begin
                errors++;
                $display("FAIL halt_stay i=%0d: got h=%b req=%b v=%b cnt=%0d want 1/0/0/2",
                         i, halted, imem_req, instr_valid, retired_count);
            end
        end
        jump = 0; branch = 0; alu_zero = 0;
    endtask

    task automatic test_reset_in_fetch();
        rand_mem = 0; mem.delete();
        do_reset();
        imem_ack = 1; instr_ready = 1;
        tick();
        tick();
        imem_ack = 0;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            errors++;
            $display("FAIL rif_pre: got req=%b addr=%h want 1/4", imem_req, imem_addr);
        end
        reset = 1;
        tick();
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'd0 ||
            instr_pc !== 32'd0 || imem_addr !== 32'd0 || retired_count !== 32'd0) begin
            errors++;
            $display("FAIL rif_reset: got req=%b v=%b instr=%h pc=%h addr=%h cnt=%0d",
                     imem_req, instr_valid, instr, instr_pc, imem_addr, retired_count);
        end
        reset = 0;
        imem_ack = 1;
        tick();
        imem_ack = 0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0 || instr_valid !== 1'b0 ||
            instr !== 32'd0) begin
            errors++;
            $display("FAIL rif_refetch: got req=%b addr=%h v=%b instr=%h want 1/0/0/0",
                     imem_req, imem_addr, instr_valid, instr);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL rif_wait: got req=%b v=%b want 1/0", imem_req, instr_valid);
        end
    endtask

    // Transaction model: after reset one quiet cycle, then a request;
    // an accepted word is offered to decode the next cycle; a consumed
    // non-halt instruction leads to a request for the resolved target.
    task automatic test_random();
        logic [31:0] m_pc, m_ipc, m_instr, m_ret, nxt;
        bit m_idle, m_req, m_valid, m_halt;
        bit r_ack, r_rdy, r_br, r_az, r_jmp, r_rst;
        int base;
        base = errors;
        rand_mem = 1; mem.delete();
        reset = 1; imem_ack = 0; instr_ready = 0;
        branch = 0; alu_zero = 0; jump = 0;
        tick();
        m_pc = 0; m_ipc = 0; m_instr = 0; m_ret = 0;
        m_idle = 1; m_req = 0; m_valid = 0; m_halt = 0;
        reset = 0;
        for (int i = 0; i < 6000 && errors - base < 10; i++) begin
            checks++;
            if ({imem_req, instr_valid, halted} !== {m_req, m_valid, m_halt}) begin
                errors++;
                $display("FAIL rnd_flags cyc=%0d: got req/v/h=%b want %b", i,
                         {imem_req, instr_valid, halted}, {m_req, m_valid, m_halt});
            end
            checks++;
            if (retired_count !== m_ret) begin
                errors++;
                $display("FAIL rnd_retired cyc=%0d: got %0d want %0d", i, retired_count, m_ret);
            end
            if (m_req) begin
                checks++;
                if (imem_addr !== m_pc) begin
                    errors++;
                    $display("FAIL rnd_addr cyc=%0d: got %h want %h", i, imem_addr, m_pc);
                end
            end
            if (m_valid) begin
                checks++;
                if (instr !== m_instr || instr_pc !== m_ipc || link_addr !== m_ipc + 32'd4) begin
                    errors++;
                    $display("FAIL rnd_buf cyc=%0d: got %h@%h link=%h want %h@%h", i,
                             instr, instr_pc, link_addr, m_instr, m_ipc);
                end
            end
            r_rst = m_halt ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0);
            r_ack = ($urandom_range(0, 2) != 0);
            r_rdy = ($urandom_range(0, 2) != 0);
            r_br  = 1'($urandom);
            r_az  = 1'($urandom);
            r_jmp = ($urandom_range(0, 3) == 0);
            reset = r_rst; imem_ack = r_ack; instr_ready = r_rdy;
            branch = r_br; alu_zero = r_az; jump = r_jmp;
            if (r_rst) begin
                m_pc = 0; m_ipc = 0; m_instr = 0; m_ret = 0;
                m_idle = 1; m_req = 0; m_valid = 0; m_halt = 0;
            end else if (m_idle) begin
                m_idle = 0;
                m_req  = 1;
            end else if (m_req && r_ack) begin
                get_word(m_pc, m_instr);
                m_ipc   = m_pc;
                m_pc    = m_pc + 32'd4;
                m_req   = 0;
                m_valid = 1;
            end else if (m_valid && r_rdy) begin
                m_ret   = m_ret + 32'd1;
                m_valid = 0;
                if (m_instr[31:26] == 6'b111111) begin
                    m_halt = 1;
                end else begin
                    m_req = 1;
                    nxt = m_ipc + 32'd4;
                    if (r_jmp)
                        m_pc = (nxt & 32'hF000_0000) | {4'b0, m_instr[25:0], 2'b00};
                    else if (r_br && r_az)
                        m_pc = nxt + 32'($signed(m_instr[15:0])) * 32'd4;
                    else
                        m_pc = nxt;
                end
            end
            tick();
        end
        reset = 0; imem_ack = 0; instr_ready = 0;
        branch = 0; alu_zero = 0; jump = 0;
    endtask

    initial begin
        reset = 1; imem_ack = 0; imem_rdata = 0; instr_ready = 0;
        branch = 0; alu_zero = 0; jump = 0;
        test_reset();
        test_seq_fetch();
        test_delayed_ack();
        test_branch();
        test_jump();
        test_stall_halt();
        test_reset_in_fetch();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage sitting directly upstream of the opcode decoder/control unit.
- Holds the PC and issues word requests to instruction memory. Buffers one fetched instruction and presents it, with its opcode field split out, to decode.
- Computes the next PC from the branch/jump controls the decoder returns for the instruction being consumed.
- Also provides the link address for jump-and-link and a retired-instruction counter.

Parameters:
ADDR_W, 32, PC/address width in bits (≥28).
RESET_PC, 0, PC value loaded on reset (word aligned).

Ports:
clk  in  1  single clock; all state on rising edge.
reset  in  1  synchronous, active-high reset.
imem_req  out  1  fetch request; held high with stable imem_addr until imem_ack.
imem_addr  out  ADDR_W  byte address of requested word (bits[1:0]=0).
imem_ack  in  1  memory returns imem_rdata this cycle; valid only while imem_req=1.
imem_rdata  in  32  instruction word.
instr  out  32  buffered instruction.
opcode  out  6  instr[31:26], feeds the control unit.
instr_pc  out  ADDR_W  address of buffered instruction.
instr_valid  out  1  buffer holds an instruction.
instr_ready  in  1  decode consumes buffered instruction this cycle when instr_valid=1.
branch  in  1  decoded branch for the consumed instruction.
alu_zero  in  1  ALU zero flag for the consumed instruction.
jump  in  1  decoded jump (j/jal) for the consumed instruction.
link_addr  out  ADDR_W  instr_pc+4, written by jal.
halted  out  1  fetch stopped by halt opcode.
retired_count  out  32  number of instructions consumed since reset.

Behaviour:
- Reset (synchronous; wins over every other event):
  - pc=RESET_PC, state=IDLE.
  - instr=0, instr_pc=0, instr_valid=0, halted=0, retired_count=0.
  - imem_req=0.
  - An in-flight request is abandoned; a late imem_ack is ignored, since ack is only honoured in FETCH.
- States: IDLE, FETCH, FULL, HALT.
- Outputs derived from registered state only:
  - imem_req=1 only in FETCH; imem_addr=pc.
  - instr_valid=1 only in FULL.
- IDLE: one cycle after reset deasserts, then → FETCH.
- FETCH, per cycle:
  - imem_ack=0: stay in FETCH, holding imem_addr.
  - imem_ack=1 (may arrive in the same cycle the request is first raised):
    - instr ← imem_rdata, instr_pc ← pc, pc ← pc+4.
    - → FULL.
- FULL with instr_ready=0: hold all state; inputs branch/jump/alu_zero are ignored.
- FULL with instr_ready=1 (consume):
  - retired_count += 1, wrapping at 2^32.
  - If opcode==6'b111111 (halt): → HALT, halted=1; pc unchanged; branch/jump ignored.
  - Else if jump: pc ← {(instr_pc+4)[ADDR_W-1:28], instr[25:0], 2'b00}.
  - Else if branch & alu_zero: pc ← instr_pc + 4 + (signext(instr[15:0]) << 2), truncated to ADDR_W (wraps).
  - Else pc unchanged (already instr_pc+4).
  - jump has priority over branch. No delay slot.
  - Non-halt → FETCH next cycle.
- HALT: no requests, instr_valid=0; exits only via reset.
- Throughput and latency:
  - Best case 1 instruction per 2 cycles (ack in FETCH cycle, ready in FULL cycle).
  - Memory latency adds cycles in FETCH; ready=0 adds cycles in FULL.
- link_addr=instr_pc+4, combinational from instr_pc.
- PC wrap: pc+4 past 2^ADDR_W-4 wraps to 0 silently.

Test Plan:
- Reset, RESET_PC=0, memory acks same cycle, ready=1 always → imem_addr sequence 0,4,8,C on cycles 2,4,6,8; retired_count=4 after 4 consumes; instr matches memory words.
- Memory ack delayed 3 cycles at addr 8 → imem_req held, imem_addr=8 stable 3 cycles; instr_valid only after ack; no address skipped.
- Consume beq (opcode 000100, imm 16'hFFFE) at pc 0x20 with branch=1, alu_zero=1 → next imem_addr=0x1C; same with alu_zero=0 → 0x24.
- Consume jal (opcode 000011, target 26'h0000040) at pc 0x1000 with jump=1, branch=1 → next imem_addr=0x100 (jump wins); link_addr=0x1004 while buffered.
- Hold ready=0 for 5 cycles in FULL → instr/instr_pc/pc stable, no imem_req, retired_count unchanged; then halt word consumed → halted=1, no further requests for 20 cycles.
- Assert reset in FETCH while imem_req=1 and then pulse imem_ack → all outputs reset values next cycle, ack ignored, refetch from RESET_PC two cycles after reset release.
